dds_sine_gen: RTL and testbench
===============================

# dds_sine_gen

Phase-accumulator sine sample generator for the variable-frequency sine path. It sits between the sample tick generator and the DAC/PWM output stages, and it drives the sine ROM address. On each sample tick it advances a phase accumulator by a switch-selected increment. It reads one or two ROM samples, optionally interpolates linearly between them, and presents a 10-bit sample with a one-cycle valid strobe to `spi2dac` / `pwm`.

## Interface

**Parameters**
- `PHASE_W`, default 20: phase accumulator width in bits (at least 16).
- `INC_SHIFT`, default 4: the phase increment is `freq_word << INC_SHIFT`.

**Ports**
- `CLOCK_50`, in, 1: system clock; all state is on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `tick`, in, 1: sample-rate enable, a one-cycle pulse.
- `freq_word`, in, 10: unsigned frequency control (SW[9:0]).
- `rom_addr`, out, 10: registered ROM address.
- `rom_data`, in, 10: ROM output. The ROM is synchronous with 1-cycle read latency on `CLOCK_50`.
- `sample_out`, out, 10: unsigned sample held between updates.
- `sample_valid`, out, 1: one-cycle pulse when `sample_out` updates.
- `overrun`, out, 1: sticky flag; a tick arrived while the FSM was busy.

## Operation

**Phase accumulator**
- `phase[PHASE_W-1:0]` increments on every `tick`, whether or not the FSM is busy.
- Update: `phase <= phase + (freq_word << INC_SHIFT)`, modulo 2^PHASE_W.
- `freq_word` is sampled on the tick edge only.

**Sample fields**
- On a tick accepted in IDLE, the pre-increment phase is latched as the working phase.
- `A` = phase[PHASE_W-1:PHASE_W-10] is the ROM address.
- `F` = phase[PHASE_W-11:PHASE_W-16] is the 6-bit fraction.

**FSM states:** IDLE, ADDR0, CAP0, CAP1, CALC, OUT.
- IDLE: on `tick`, latch A and F, set `rom_addr <= A`, go to ADDR0.
- ADDR0: wait for ROM latency; `rom_addr <= A+1` (mod 1024, so 1023 wraps to 0). Go to CAP0.
- CAP0: capture `d0 = rom_data`. Go to CAP1.
- CAP1: capture `d1 = rom_data`. Go to CALC.
- CALC: compute the interpolated result and register it into `sample_out`. Go to OUT.
- OUT: `sample_valid = 1` for exactly this cycle. Go to IDLE.

**Interpolation arithmetic**
- `diff = d1 - d0`, signed 11-bit.
- `prod = diff * F`, signed 17-bit.
- `result = d0 + (prod >>> 6)`: arithmetic shift, rounds toward minus infinity.
- The result always lies within [min(d0,d1), max(d0,d1)], so no saturation is needed.

**Overrun**
- A tick in any non-IDLE state still advances `phase`.
- That tick does not start a sample.
- It sets `overrun` to 1; `overrun` clears only on `rst`.

**Zero frequency:** `freq_word = 0` holds the phase fixed, so every tick re-emits the same sample with a `sample_valid` pulse.

**Reset values**
- `phase = 0`, state IDLE, `rom_addr = 0`.
- `sample_out = 10'd512` (mid-scale).
- `sample_valid = 0`, `overrun = 0`.
- Reset mid-sequence aborts it; no valid pulse is issued for the aborted sample.

## Timing

- Tick high in cycle k with `INTERP_EN` defined:
  - `rom_addr = A` in k+1, `rom_addr = A+1` in k+2.
  - `d0` is captured at the end of k+2 and `d1` at the end of k+3.
  - `sample_out` changes and `sample_valid = 1` in cycle k+5.
- Without `INTERP_EN`: `sample_out = d0` and `sample_valid = 1` in cycle k+3.
- Minimum tick spacing without overrun: 6 cycles (interp) or 4 cycles (non-interp). A tick in the OUT cycle counts as overrun.
- `sample_out` is stable from its valid pulse until the next valid pulse.

## Configuration

- Macro: `DDS_INTERP_EN`.
- Defined: full FSM as above, with two ROM reads and linear interpolation by F.
- Undefined:
  - CAP1 and CALC are removed; CAP0 goes to OUT with `sample_out <= d0` registered on that edge.
  - F is ignored and `rom_addr` never presents A+1.
  - The phase accumulator and overrun behaviour are unchanged.

## Test plan

Defaults throughout: `PHASE_W` = 20, `INC_SHIFT` = 4.

1. **Reset:** assert `rst` mid-sequence (state CAP0). Required: `sample_out` = 512, `sample_valid` = 0, `overrun` = 0, `rom_addr` = 0 immediately, and no valid pulse after release.
2. **Integer step:** `freq_word` = 64 (increment 1024), ticks every 5000 cycles. Required: `rom_addr` = 0, 1, 2, … on successive ticks, F = 0, `sample_out` = ROM[n], and wrap 1023 → 0 after 1024 ticks.
3. **Interpolation (`DDS_INTERP_EN`):** `freq_word` = 32 with ROM[0] = 100, ROM[1] = 200. Required: second sample = 150 (F = 32), `sample_valid` exactly 5 cycles after the tick. With ROM[0] = 200, ROM[1] = 100, the sample is also 150.
4. **Address wrap in interpolation:** phase preset so A = 1023, F = 16, with ROM[1023] = 500, ROM[0] = 504. Required: second read address 0, `sample_out` = 501.
5. **Overrun:** two ticks 3 cycles apart with `freq_word` = 64. Required: one valid pulse only, `overrun` = 1 and sticky, and phase advanced by 2048.
6. **Zero frequency:** `freq_word` = 0 across 3 ticks. Required: 3 valid pulses with identical `sample_out` and `rom_addr` constant.

Source files
------------

// File: rtl/dds_sine_gen.sv
// Phase-accumulator sine sampler: tick-driven phase step, sine ROM read(s), optional linear interpolation.
// Optional feature macro: DDS_INTERP_EN (two ROM reads + interpolation by the 6-bit phase fraction).
module dds_sine_gen #(
  parameter int PHASE_W   = 20,
  parameter int INC_SHIFT = 4
) (
  input  logic       CLOCK_50,
  input  logic       rst,
  input  logic       tick,
  input  logic [9:0] freq_word,
  output logic [9:0] rom_addr,
  input  logic [9:0] rom_data,
  output logic [9:0] sample_out,
  output logic       sample_valid,
  output logic       overrun
);

`ifdef DDS_INTERP_EN
  typedef enum logic [2:0] {S_IDLE, S_ADDR0, S_CAP0, S_CAP1, S_CALC, S_OUT} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_ADDR0, S_CAP0, S_OUT} state_t;
`endif

  state_t state, state_nxt;

  logic [PHASE_W-1:0] phase;
  logic [PHASE_W-1:0] inc;
  logic [9:0]         a_q;

  assign inc = PHASE_W'(freq_word) << INC_SHIFT;

`ifdef DDS_INTERP_EN
  logic [5:0]         f_q;
  logic [9:0]         d0;
  logic [9:0]         d1;
  logic signed [10:0] diff;
  logic signed [16:0] prod;
  logic [9:0]         interp_res;

  // Result always lies between d0 and d1, so modulo-1024 addition is exact.
  always_comb begin
    diff       = $signed({1'b0, d1}) - $signed({1'b0, d0});
    prod       = diff * $signed({1'b0, f_q});
    interp_res = d0 + 10'(prod >>> 6);
  end
`endif

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (tick) state_nxt = S_ADDR0;
      S_ADDR0: state_nxt = S_CAP0;
`ifdef DDS_INTERP_EN
      S_CAP0:  state_nxt = S_CAP1;
      S_CAP1:  state_nxt = S_CALC;
      S_CALC:  state_nxt = S_OUT;
`else
      S_CAP0:  state_nxt = S_OUT;
`endif
      S_OUT:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      phase        <= '0;
      a_q          <= '0;
      rom_addr     <= '0;
      sample_out   <= 10'd512;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
`ifdef DDS_INTERP_EN
      f_q          <= '0;
      d0           <= '0;
      d1           <= '0;
`endif
    end else begin
      sample_valid <= (state_nxt == S_OUT);
      // The accumulator never stalls; a busy FSM just drops the sample.
      if (tick) begin
        phase <= phase + inc;
        if (state != S_IDLE) overrun <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (tick) begin
            a_q      <= phase[PHASE_W-1 -: 10];
            rom_addr <= phase[PHASE_W-1 -: 10];
`ifdef DDS_INTERP_EN
            f_q      <= phase[PHASE_W-11 -: 6];
`endif
          end
        end
`ifdef DDS_INTERP_EN
        S_ADDR0: rom_addr <= a_q + 10'd1;
        S_CAP0:  d0 <= rom_data;
        S_CAP1:  d1 <= rom_data;
        S_CALC:  sample_out <= interp_res;
`else
        S_CAP0:  sample_out <= rom_data;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dds_sine_gen.sv
// Scoreboard bench for dds_sine_gen: stimulus pushes expected samples, a monitor pops on sample_valid.
module tb_dds_sine_gen;

`ifdef DDS_INTERP_EN
  localparam int  LAT    = 5;
  localparam bit  INTERP = 1'b1;
`else
  localparam int  LAT    = 3;
  localparam bit  INTERP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic [9:0] freq_word = '0;
  logic [9:0] rom_addr;
  logic [9:0] rom_data = '0;
  logic [9:0] sample_out;
  logic       sample_valid;
  logic       overrun;

  dds_sine_gen #(.PHASE_W(20), .INC_SHIFT(4)) dut (
    .CLOCK_50    (clk),
    .rst         (rst),
    .tick        (tick),
    .freq_word   (freq_word),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .sample_out  (sample_out),
    .sample_valid(sample_valid),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  logic [9:0] rom [1024];
  always @(posedge clk) rom_data <= rom[rom_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [9:0] val;
    int         cyc;
  } exp_t;
  exp_t q[$];

  int         checks = 0;
  int         errors = 0;
  logic [19:0] m_phase = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] model(input logic [19:0] ph);
    logic [9:0] a;
    logic [5:0] f;
    int d0, d1, prod;
    a  = ph[19:10];
    f  = ph[9:4];
    d0 = int'(rom[a]);
    d1 = int'(rom[a + 10'd1]);
    prod = (d1 - d0) * int'(f);
    if (INTERP) return 10'(d0 + (prod >>> 6));
    else        return 10'(d0);
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    q.delete();
    m_phase = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic fill_rom();
    for (int i = 0; i < 1024; i++) rom[i] = 10'((i * 37 + 5) & 1023);
  endtask

  // Issues one tick; returns at the negedge of the cycle after the tick.
  task automatic do_tick(input logic [9:0] fw, input bit accept, input bit use_model,
                         input logic [9:0] hand);
    exp_t e;
    @(negedge clk);
    if (accept) begin
      e.val = use_model ? model(m_phase) : hand;
      e.cyc = cyc + LAT;
      q.push_back(e);
    end
    freq_word = fw;
    tick      = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    if (accept) check("rom_addr_A", rom_addr, m_phase[19:10]);
    m_phase = m_phase + ({10'd0, fw} << 4);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && sample_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: sample_out=%0d with no sample pending (t=%0t)",
                 sample_out, $time);
      end else begin
        e = q.pop_front();
        check("sample_out", sample_out, e.val);
        check("valid_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d samples pending", q.size());
    $fatal(1);
  end

  initial begin
    fill_rom();
    wait_cycles(3);
    check("rst_sample_out", sample_out, 10'd512);
    check("rst_valid", sample_valid, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_rom_addr", rom_addr, 10'd0);
    rst = 1'b0;

    // Reset asserted while the FSM is in CAP0 of the second sample.
    do_tick(10'd64, 1'b1, 1'b1, 10'd0);
    wait_cycles(7);
    do_tick(10'd64, 1'b1, 1'b1, 10'd0);
    @(negedge clk);
    rst = 1'b1;
    q.delete();
    m_phase = '0;
    #1;
    check("midrst_rom_addr", rom_addr, 10'd0);
    check("midrst_sample_out", sample_out, 10'd512);
    check("midrst_valid", sample_valid, 1'b0);
    check("midrst_overrun", overrun, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    wait_cycles(10);

    // Integer step through the whole table, including the 1023 -> 0 wrap.
    apply_reset();
    for (int n = 0; n <= 1024; n++) begin
      do_tick(10'd64, 1'b1, 1'b1, 10'd0);
      wait_cycles(7);
    end

    // Half-step interpolation, rising and falling.
    apply_reset();
    rom[0] = 10'd100;
    rom[1] = 10'd200;
    do_tick(10'd32, 1'b1, 1'b0, 10'd100);
    wait_cycles(7);
    do_tick(10'd32, 1'b1, 1'b0, INTERP ? 10'd150 : 10'd100);
    wait_cycles(7);
    apply_reset();
    rom[0] = 10'd200;
    rom[1] = 10'd100;
    do_tick(10'd32, 1'b1, 1'b0, 10'd200);
    wait_cycles(7);
    do_tick(10'd32, 1'b1, 1'b0, INTERP ? 10'd150 : 10'd200);
    wait_cycles(7);

    // Walk phase to A=1023, F=16: 64*1023 + 16 increments of 16.
    apply_reset();
    fill_rom();
    for (int i = 0; i < 64; i++) begin
      do_tick(10'd1023, 1'b1, 1'b1, 10'd0);
      wait_cycles(7);
    end
    do_tick(10'd16, 1'b1, 1'b1, 10'd0);
    wait_cycles(7);
    check("preset_phase", m_phase, 20'hFFD00);
    rom[1023] = 10'd500;
    rom[0]    = 10'd504;
    do_tick(10'd0, 1'b1, 1'b0, INTERP ? 10'd501 : 10'd500);
    @(negedge clk);
    check("wrap_addr_second", rom_addr, INTERP ? 10'd0 : 10'd1023);
    wait_cycles(7);

    // Overrun: second tick three cycles after the first.
    apply_reset();
    rom[0] = 10'd11;
    rom[1] = 10'd22;
    rom[2] = 10'd33;
    rom[3] = 10'd44;
    do_tick(10'd64, 1'b1, 1'b0, 10'd11);
    check("overrun_before", overrun, 1'b0);
    wait_cycles(1);
    do_tick(10'd64, 1'b0, 1'b0, 10'd0);
    check("overrun_set", overrun, 1'b1);
    wait_cycles(8);
    do_tick(10'd64, 1'b1, 1'b0, 10'd33);
    wait_cycles(8);
    check("overrun_sticky", overrun, 1'b1);

    // Zero frequency: same sample three times.
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      do_tick(10'd0, 1'b1, 1'b0, 10'd11);
      wait_cycles(7);
    end

    wait_cycles(10);
    check("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
